// File: rtl/rgb_tx_scheduler.sv
// rgb_tx_scheduler: round-robin arbiter sharing one RGB byte serializer
// between two pixel requesters, with byte-pulse completion and watchdog.
module rgb_tx_scheduler #(
    parameter int BYTE_PERIOD = 4000,
    parameter int TIMEOUT     = 16000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        en,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] rgb0,
    input  logic [23:0] rgb1,
    output logic        ack0,
    output logic        ack1,
    input  logic        ser_ready,
    output logic        ser_valid,
    output logic [7:0]  ser_r,
    output logic [7:0]  ser_g,
    output logic [7:0]  ser_b,
    output logic        busy,
    output logic        grant_id,
    output logic [15:0] pixel_cnt,
    output logic        timeout_err
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(BYTE_PERIOD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          ser_valid_q, ser_valid_d;
    logic [23:0]   pix_q, pix_d;
    logic          busy_q, busy_d;
    logic          grant_id_q, grant_id_d;
    logic          last_grant_q, last_grant_d;
    logic [15:0]   pixel_cnt_q, pixel_cnt_d;
    logic          timeout_err_q, timeout_err_d;
    logic [1:0]    pulse_cnt_q, pulse_cnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          win;

    // Next-state: arbitration in IDLE, byte counting and watchdog in WAIT
    always_comb begin
        state_d       = state_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        ser_valid_d   = 1'b0;
        pix_d         = pix_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        pixel_cnt_d   = pixel_cnt_q;
        timeout_err_d = timeout_err_q;
        pulse_cnt_d   = pulse_cnt_q;
        wdog_d        = wdog_q;
        gap_cnt_d     = gap_cnt_q;
        win           = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (en && (req0 || req1)) begin
                    win          = (req0 && req1) ? ~last_grant_q : req1;
                    pix_d        = win ? rgb1 : rgb0;
                    grant_id_d   = win;
                    last_grant_d = win;
                    ack0_d       = ~win;
                    ack1_d       = win;
                    ser_valid_d  = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pulse_cnt_d = 2'd0;
                wdog_d      = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (ser_ready) begin
                    pulse_cnt_d = pulse_cnt_q + 2'd1;
                end
                if (ser_ready && pulse_cnt_q == 2'd2) begin
                    gap_cnt_d   = GW'(BYTE_PERIOD - 1);
                    pixel_cnt_d = pixel_cnt_q + 16'd1;
                    state_d     = S_GAP;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            ser_valid_q   <= 1'b0;
            pix_q         <= 24'd0;
            busy_q        <= 1'b0;
            grant_id_q    <= 1'b0;
            last_grant_q  <= 1'b1;
            pixel_cnt_q   <= 16'd0;
            timeout_err_q <= 1'b0;
            pulse_cnt_q   <= 2'd0;
            wdog_q        <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            ser_valid_q   <= ser_valid_d;
            pix_q         <= pix_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            pixel_cnt_q   <= pixel_cnt_d;
            timeout_err_q <= timeout_err_d;
            pulse_cnt_q   <= pulse_cnt_d;
            wdog_q        <= wdog_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign ser_valid   = ser_valid_q;
    assign ser_r       = pix_q[23:16];
    assign ser_g       = pix_q[15:8];
    assign ser_b       = pix_q[7:0];
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign pixel_cnt   = pixel_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rgb_tx_scheduler.sv
// tb_rgb_tx_scheduler: scoreboard bench with a byte serializer model;
// expected grants and bytes are queued at stimulus time.
module tb_rgb_tx_scheduler;

    localparam int BP = 8;
    localparam int TO = 32;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        en = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [23:0] rgb0 = 24'd0;
    logic [23:0] rgb1 = 24'd0;
    logic        ack0, ack1, ser_valid, busy, grant_id, timeout_err;
    logic [7:0]  ser_r, ser_g, ser_b;
    logic [15:0] pixel_cnt;
    logic        ser_ready;
    logic        mdl_ready, inj_ready = 1'b0, stall = 1'b0;
    logic [7:0]  mdl_byte;
    logic [23:0] mdl_pix;
    logic        mdl_act;
    int          mdl_cnt, mdl_idx;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  exp_bytes[$];
    logic        exp_gnt[$];
    logic        gexp;
    logic [7:0]  bexp;
    logic        prev_ack = 1'b0, prev_busy = 1'b0;

    assign ser_ready = mdl_ready | inj_ready;

    always #5 sys_clk = ~sys_clk;

    rgb_tx_scheduler #(.BYTE_PERIOD(BP), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
        .req0(req0), .req1(req1), .rgb0(rgb0), .rgb1(rgb1),
        .ack0(ack0), .ack1(ack1), .ser_ready(ser_ready),
        .ser_valid(ser_valid), .ser_r(ser_r), .ser_g(ser_g), .ser_b(ser_b),
        .busy(busy), .grant_id(grant_id), .pixel_cnt(pixel_cnt),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serializer model: one byte pulse every BP cycles after a valid strobe
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mdl_act   <= 1'b0;
            mdl_ready <= 1'b0;
            mdl_cnt   <= 0;
            mdl_idx   <= 0;
            mdl_byte  <= 8'd0;
            mdl_pix   <= 24'd0;
        end else begin
            mdl_ready <= 1'b0;
            if (ser_valid) begin
                mdl_act <= 1'b1;
                mdl_pix <= {ser_r, ser_g, ser_b};
                mdl_cnt <= 0;
                mdl_idx <= 0;
            end else if (mdl_act) begin
                if (mdl_cnt == BP - 1) begin
                    mdl_cnt   <= 0;
                    mdl_idx   <= mdl_idx + 1;
                    mdl_ready <= !stall;
                    mdl_byte  <= mdl_pix[23 - 8 * mdl_idx -: 8];
                    if (mdl_idx == 2) mdl_act <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt + 1;
                end
            end
        end
    end

    // Monitor: pops expected grants on acks and expected bytes on pulses
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_ack  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (prev_ack) check("ack_pulse", {ack1, ack0}, 0);
            if (ack0 || ack1) begin
                check("ack_valid", ser_valid, 1);
                check("ack_from_idle", prev_busy, 0);
                if (exp_gnt.size() == 0) begin
                    check("gnt_q_size", exp_gnt.size(), 1);
                end else begin
                    gexp = exp_gnt.pop_front();
                    check("grant_id", grant_id, gexp);
                    check("ack_sel", {ack1, ack0}, gexp ? 2 : 1);
                end
            end
            if (mdl_ready) begin
                if (exp_bytes.size() == 0) begin
                    check("byte_q_size", exp_bytes.size(), 1);
                end else begin
                    bexp = exp_bytes.pop_front();
                    check("ser_byte", mdl_byte, bexp);
                end
            end
            prev_ack  = ack0 | ack1;
            prev_busy = busy;
        end
    end

    task automatic push_pix(input logic g, input logic [23:0] p);
        exp_gnt.push_back(g);
        exp_bytes.push_back(p[23:16]);
        exp_bytes.push_back(p[15:8]);
        exp_bytes.push_back(p[7:0]);
    endtask

    task automatic wait_ack(input int max);
        int n = 0;
        @(negedge sys_clk);
        while (!(ack0 || ack1) && n < max) begin
            @(negedge sys_clk);
            n++;
        end
        check("ack_bound", ack0 | ack1, 1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        @(negedge sys_clk);
        while (busy && n < max) begin
            @(negedge sys_clk);
            n++;
        end
        check("idle_bound", busy, 0);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", ser_valid, 0);
        check("rst_ack", {ack1, ack0}, 0);
        check("rst_gid", grant_id, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_pcnt", pixel_cnt, 0);
        check("rst_rgb", {ser_r, ser_g, ser_b}, 0);
        exp_bytes.delete();
        exp_gnt.delete();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "global timeout");
    end

    initial begin
        #2;
        do_reset();
        en = 1'b1;

        // single request
        @(negedge sys_clk);
        rgb0 = 24'h112233;
        req0 = 1'b1;
        push_pix(1'b0, 24'h112233);
        @(negedge sys_clk);
        check("t1_ack0", ack0, 1);
        check("t1_valid", ser_valid, 1);
        req0 = 1'b0;
        wait_idle(100);
        check("t1_pcnt", pixel_cnt, 1);
        check("t1_hold", {ser_r, ser_g, ser_b}, 24'h112233);
        inj_ready = 1'b1;
        @(negedge sys_clk);
        inj_ready = 1'b0;
        @(negedge sys_clk);
        check("idle_rdy_terr", timeout_err, 0);
        check("idle_rdy_pcnt", pixel_cnt, 1);
        check("idle_rdy_busy", busy, 0);

        // tie requests alternate
        do_reset();
        rgb0 = 24'hA0A1A2;
        rgb1 = 24'hB0B1B2;
        push_pix(1'b0, 24'hA0A1A2);
        push_pix(1'b1, 24'hB0B1B2);
        push_pix(1'b0, 24'hC0C1C2);
        push_pix(1'b1, 24'hD0D1D2);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(200);
            if (i == 0) rgb0 = 24'hC0C1C2;
            if (i == 1) rgb1 = 24'hD0D1D2;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle(100);
        check("t2_pcnt", pixel_cnt, 4);

        // watchdog abort
        rgb0 = 24'h0F0F0F;
        req0 = 1'b1;
        stall = 1'b1;
        exp_gnt.push_back(1'b0);
        @(negedge sys_clk);
        check("t3_ack0", ack0, 1);
        req0 = 1'b0;
        repeat (TO) @(negedge sys_clk);
        check("t3_busy_last", busy, 1);
        check("t3_terr_early", timeout_err, 0);
        @(negedge sys_clk);
        check("t3_busy_abort", busy, 0);
        check("t3_terr", timeout_err, 1);
        check("t3_pcnt", pixel_cnt, 4);
        stall = 1'b0;
        rgb1 = 24'h445566;
        req1 = 1'b1;
        push_pix(1'b1, 24'h445566);
        wait_ack(50);
        req1 = 1'b0;
        wait_idle(100);
        check("t3_terr_sticky", timeout_err, 1);
        check("t3_pcnt2", pixel_cnt, 5);

        // enable gating
        rgb0 = 24'h778899;
        req0 = 1'b1;
        push_pix(1'b0, 24'h778899);
        wait_ack(50);
        req0 = 1'b0;
        en = 1'b0;
        rgb1 = 24'hAABBCC;
        req1 = 1'b1;
        wait_idle(100);
        repeat (10) @(negedge sys_clk);
        check("t4_no_ack1", ack1, 0);
        check("t4_pcnt", pixel_cnt, 6);
        en = 1'b1;
        push_pix(1'b1, 24'hAABBCC);
        wait_ack(10);
        req1 = 1'b0;
        rgb0 = 24'hDDEEFF;
        req0 = 1'b1;
        en = 1'b0;
        repeat (4) @(negedge sys_clk);
        en = 1'b1;
        push_pix(1'b0, 24'hDDEEFF);
        wait_ack(200);
        check("t4_after_done", pixel_cnt, 7);
        req0 = 1'b0;
        wait_idle(100);
        check("t4_pcnt2", pixel_cnt, 8);

        // reset mid-wait
        rgb1 = 24'h5A5A5A;
        req1 = 1'b1;
        push_pix(1'b1, 24'h5A5A5A);
        wait_ack(50);
        req1 = 1'b0;
        repeat (BP + 3) @(negedge sys_clk);
        check("t5_in_wait", busy, 1);
        #2;
        do_reset();
        rgb0 = 24'h010203;
        rgb1 = 24'h040506;
        req0 = 1'b1;
        req1 = 1'b1;
        push_pix(1'b0, 24'h010203);
        @(negedge sys_clk);
        check("t5_tie_ack0", ack0, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle(100);
        check("t5_pcnt", pixel_cnt, 1);

        // counter wrap
        @(negedge sys_clk);
        force dut.pixel_cnt_q = 16'hFFFF;
        @(negedge sys_clk);
        release dut.pixel_cnt_q;
        @(negedge sys_clk);
        check("t6_pre", pixel_cnt, 16'hFFFF);
        rgb0 = 24'hFEDCBA;
        req0 = 1'b1;
        push_pix(1'b0, 24'hFEDCBA);
        wait_ack(10);
        req0 = 1'b0;
        wait_idle(100);
        check("t6_wrap", pixel_cnt, 0);

        repeat (3) @(negedge sys_clk);
        check("bytes_left", exp_bytes.size(), 0);
        check("gnts_left", exp_gnt.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
